// File: rtl/sfp_link_ctrl.sv
// SFP port supervisor for ETH0: synchronizes and debounces the module status pins,
// sequences TX_DISABLE, runs the fault-recovery retry loop with lockout and qualifies link_ok.
module sfp_link_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned STARTUP_CYCLES  = 100000,
  parameter int unsigned SETTLE_CYCLES   = 50000,
  parameter int unsigned FAULT_HOLD      = 1000,
  parameter int unsigned MAX_RETRY       = 3
) (
  input  logic       clk100,
  input  logic       sys_rst,
  input  logic       sfp_tx_fault,
  input  logic       sfp_rx_los,
  input  logic       sfp_clk_alarm_b,
  input  logic       pcs_block_lock,
  input  logic       clear_lockout,
  output logic       sfp_tx_disable,
  output logic       link_ok,
  output logic       tx_fault_db,
  output logic       rx_los_db,
  output logic       clk_alarm_db,
  output logic [3:0] retry_cnt,
  output logic [2:0] state
);

  localparam logic [2:0] ST_RESET_HOLD = 3'd0;
  localparam logic [2:0] ST_ENABLE     = 3'd1;
  localparam logic [2:0] ST_RUN        = 3'd2;
  localparam logic [2:0] ST_FAULT      = 3'd3;
  localparam logic [2:0] ST_LOCKOUT    = 3'd4;

  localparam logic [23:0] DEB_LAST     = 24'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0] STARTUP_LAST = 24'(STARTUP_CYCLES - 1);
  localparam logic [23:0] SETTLE_LAST  = 24'(SETTLE_CYCLES - 1);
  localparam logic [23:0] FAULT_LAST   = 24'(FAULT_HOLD - 1);
  localparam logic [23:0] TIMER_MAX    = 24'hFF_FFFF;
  localparam logic [3:0]  RETRY_MAX    = 4'(MAX_RETRY);

  // Synchronizer bit order {lock, alarm_b, los, fault}; idle values assume a dark, unlocked port.
  localparam logic [3:0]  SYNC_RST     = 4'b0110;
  // Debounced flag order {alarm (active-high), los, fault}.
  localparam logic [2:0]  DB_RST       = 3'b010;

  logic [3:0]       pins_s;
  logic [3:0]       sync1_q;
  logic [3:0]       sync2_q;
  logic [2:0]       db_in_s;
  logic [2:0]       db_q;
  logic [2:0]       db_d;
  logic [2:0][23:0] db_cnt_q;
  logic [2:0][23:0] db_cnt_d;
  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [23:0]      timer_q;
  logic [23:0]      timer_d;
  logic [3:0]       retry_q;
  logic [3:0]       retry_d;
  logic             tx_disable_q;
  logic             tx_disable_d;
  logic             link_ok_q;
  logic             link_ok_d;
  logic             fault_db_s;

  assign pins_s     = {pcs_block_lock, sfp_clk_alarm_b, sfp_rx_los, sfp_tx_fault};
  assign db_in_s    = {~sync2_q[2], sync2_q[1], sync2_q[0]};
  assign fault_db_s = db_q[0];

  // Two-flop synchronizers for all asynchronous status inputs.
  always_ff @(posedge clk100 or posedge sys_rst) begin
    if (sys_rst) begin
      sync1_q <= SYNC_RST;
      sync2_q <= SYNC_RST;
    end else begin
      sync1_q <= pins_s;
      sync2_q <= sync1_q;
    end
  end

  // Debounce next-state: a flag only follows its input after DEBOUNCE_CYCLES disagreeing cycles.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (db_in_s[i] == db_q[i]) begin
        db_cnt_d[i] = 24'd0;
      end else if (db_cnt_q[i] == DEB_LAST) begin
        db_d[i]     = db_in_s[i];
        db_cnt_d[i] = 24'd0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 24'd1;
      end
    end
  end

  // Debounce registers.
  always_ff @(posedge clk100 or posedge sys_rst) begin
    if (sys_rst) begin
      db_q     <= DB_RST;
      db_cnt_q <= '0;
    end else begin
      db_q     <= db_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk100 or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_RESET_HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; a fault in ENABLE takes priority over settle completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET_HOLD: begin
        if (timer_q == STARTUP_LAST) state_d = ST_ENABLE;
        else                         state_d = ST_RESET_HOLD;
      end
      ST_ENABLE: begin
        if (fault_db_s)                   state_d = ST_FAULT;
        else if (timer_q == SETTLE_LAST)  state_d = ST_RUN;
        else                              state_d = ST_ENABLE;
      end
      ST_RUN: begin
        if (fault_db_s) state_d = ST_FAULT;
        else            state_d = ST_RUN;
      end
      ST_FAULT: begin
        if (timer_q == FAULT_LAST) begin
          if (retry_q >= RETRY_MAX) state_d = ST_LOCKOUT;
          else                      state_d = ST_ENABLE;
        end else begin
          state_d = ST_FAULT;
        end
      end
      ST_LOCKOUT: begin
        if (clear_lockout) state_d = ST_RESET_HOLD;
        else               state_d = ST_LOCKOUT;
      end
      default: state_d = ST_RESET_HOLD;
    endcase
  end

  // FSM output logic: timer, retry counter, TX_DISABLE decode and link qualification.
  always_comb begin
    timer_d      = timer_q;
    retry_d      = retry_q;
    tx_disable_d = 1'b1;
    link_ok_d    = 1'b0;

    if (state_d != state_q) begin
      timer_d = 24'd0;
    end else if ((state_q == ST_RUN) && (timer_q == SETTLE_LAST)) begin
      timer_d = timer_q;
    end else if (timer_q != TIMER_MAX) begin
      timer_d = timer_q + 24'd1;
    end else begin
      timer_d = timer_q;
    end

    if ((state_d == ST_FAULT) && (state_q != ST_FAULT)) begin
      if (retry_q >= RETRY_MAX) retry_d = retry_q;
      else                      retry_d = retry_q + 4'd1;
    end else if ((state_q == ST_RUN) && (state_d == ST_RUN) && (timer_q == SETTLE_LAST)) begin
      retry_d = 4'd0;
    end else if ((state_q == ST_LOCKOUT) && (state_d == ST_RESET_HOLD)) begin
      retry_d = 4'd0;
    end else begin
      retry_d = retry_q;
    end

    if ((state_d == ST_ENABLE) || (state_d == ST_RUN)) tx_disable_d = 1'b0;
    else                                               tx_disable_d = 1'b1;

    // LOS, alarm and lock loss only gate link_ok; they never move the FSM.
    link_ok_d = (state_q == ST_RUN) & ~db_q[1] & ~db_q[2] & sync2_q[3];
  end

  // Registered FSM outputs and datapath.
  always_ff @(posedge clk100 or posedge sys_rst) begin
    if (sys_rst) begin
      timer_q      <= 24'd0;
      retry_q      <= 4'd0;
      tx_disable_q <= 1'b1;
      link_ok_q    <= 1'b0;
    end else begin
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      tx_disable_q <= tx_disable_d;
      link_ok_q    <= link_ok_d;
    end
  end

  assign sfp_tx_disable = tx_disable_q;
  assign link_ok        = link_ok_q;
  assign tx_fault_db    = db_q[0];
  assign rx_los_db      = db_q[1];
  assign clk_alarm_db   = db_q[2];
  assign retry_cnt      = retry_q;
  assign state          = state_q;

endmodule
